time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
BCD hours/minutes/seconds timekeeper that consumes the slow square waves produced by the system clock divider and turns them into a 24-hour time of day. It runs entirely in the 100 MHz CP domain. It synchronises the 1 Hz and 10 Hz divider outputs, converts their rising edges into single-cycle strobes and drives seconds/minutes/hours counters. It also provides set/adjust modes and an hourly chime strobe for the display and alarm logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each tick synchroniser (allowed 2..3).
HOUR_WRAP, 24, hour modulus; legal values 12 or 24; 12 counts 1..12, 24 counts 0..23.

Ports:
CP  input  1  system clock, 100 MHz.
_CR  input  1  asynchronous reset, active low.
tick_1hz  input  1  1 Hz square wave from the divider, asynchronous to CP edges.
tick_10hz  input  1  10 Hz square wave from the divider, used for adjust auto-repeat.
mode  input  2  00 run, 01 set hour, 10 set minute, 11 hold (frozen).
adj  input  1  adjust button level, synchronised and debounced upstream.
sec_clr  input  1  synchronous seconds clear, active high.
hour_bcd  output  8  hours in BCD, tens in [7:4], units in [3:0].
min_bcd  output  8  minutes in BCD.
sec_bcd  output  8  seconds in BCD.
sec_strobe  output  1  one-CP pulse on each accepted second advance.
chime  output  1  one-CP pulse when minutes:seconds roll 59:59 -> 00:00 in run mode.

Behaviour:
- One clock (CP). Reset _CR is asynchronous and active-low.
- Reset values:
  - hour_bcd = 00 for HOUR_WRAP=24, 12 for HOUR_WRAP=12.
  - min_bcd = 00, sec_bcd = 00, sec_strobe = 0, chime = 0.
  - Synchroniser stages and edge-detect history all clear to 0.
- Tick input path:
  - Each tick input passes through a SYNC_STAGES flip-flop chain, then a 1-deep history register.
  - Strobe s1 / s10 = synced & ~history, so it is exactly one CP wide per rising edge.
  - Latency from the input edge to the strobe is SYNC_STAGES+1 CP cycles.
  - Falling edges produce nothing.
- mode 00 (run), on s1:
  - sec +1, with BCD units/tens handled digit-wise.
  - 59 -> 00 carries into minutes; minute 59 -> 00 carries into hours; hour wraps 23 -> 00 (24h) or 12 -> 01 (12h).
  - All carries resolve in the same CP cycle as s1; registered outputs update on the next CP edge.
  - sec_strobe is asserted in the same cycle the new seconds value appears.
  - chime pulses in the cycle min/sec become 00:00.
- mode 01 (set hour):
  - Seconds are frozen.
  - Each s10 with adj=1 advances hours by 1 with wrap and no carry out. This gives 10 steps/s auto-repeat.
  - adj=0 means no change.
- mode 10 (set minute):
  - Same as mode 01 but advances minutes, wrapping 59 -> 00 with no carry into hours.
  - Seconds are cleared to 00 on entry, i.e. in the first cycle mode==10.
- mode 11 (hold):
  - All counters frozen.
  - s1 and s10 are ignored and no strobes are output.
- sec_clr=1, any mode:
  - Seconds go to 00 on the next CP edge.
  - It takes priority over a coincident s1 increment; that tick is dropped and no carry is generated.
  - Minutes and hours are unaffected.
- Mode change coincident with a strobe: the mode value sampled in that cycle governs.
- Strobe timing: s1 and s10 coincident in run mode means only s1 acts. sec_strobe fires only in run mode.
- Counters never hold illegal BCD; any illegal value (unreachable) recovers to 0 on the next increment.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately (asynchronously).
  - The first strobe after release requires a fresh rising edge seen by the synchroniser. A tick input that is already high at release does not count.

Test Plan:
- Reset, then mode=00 and 3 rising edges on tick_1hz -> sec_bcd=03, exactly 3 one-cycle sec_strobe pulses, each SYNC_STAGES+2 CP after its edge.
- Preload via set modes to 23:59:58, run 2 ticks -> 23:59:59, then 00:00:00. chime pulses once with the rollover; hour_bcd=00.
- HOUR_WRAP=12 at 12:59:59 plus 1 tick -> 01:00:00.
- mode=01 with adj=1 for 5 tick_10hz edges from 22 -> 03. Then mode=10 with adj=1 for 3 edges from 58 -> 01 and hours unchanged. sec_bcd=00 upon entry to mode 10.
- sec_clr asserted in the same cycle as s1 at sec=59, min=10 -> sec=00, min stays 10, no chime. mode=11 with 10 ticks -> no change and no sec_strobe.
- Assert _CR low mid-count at 07:31:42 -> 00:00:00 asynchronously. Release with tick_1hz held high -> no increment until the next rising edge.

Source files
------------

// File: rtl/time_keeper.sv
// BCD 24h/12h time-of-day counter driven by the divider's 1 Hz / 10 Hz square waves.
// Ticks are synchronised into CP, edge-detected into one-cycle strobes, and feed run/set/hold modes.
module time_keeper #(
  parameter int SYNC_STAGES = 2,
  parameter int HOUR_WRAP   = 24
) (
  input  logic       CP,
  input  logic       _CR,
  input  logic       tick_1hz,
  input  logic       tick_10hz,
  input  logic [1:0] mode,
  input  logic       adj,
  input  logic       sec_clr,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       sec_strobe,
  output logic       chime
);

  localparam int         LAST       = SYNC_STAGES - 1;
  localparam logic [7:0] HOUR_TOP   = (HOUR_WRAP == 12) ? 8'h12 : 8'h23;
  localparam logic [7:0] HOUR_BASE  = (HOUR_WRAP == 12) ? 8'h01 : 8'h00;
  localparam logic [7:0] HOUR_RESET = (HOUR_WRAP == 12) ? 8'h12 : 8'h00;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_t;

  // Two-digit BCD increment with wrap; malformed digits recover to zero.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] top,
                                         input logic [7:0] base);
    logic [7:0] r;
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v > top)
      r = 8'h00;
    else if (v == top)
      r = base;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync1_reg, sync1_next;
  logic [SYNC_STAGES-1:0] sync10_reg, sync10_next;
  logic [SYNC_STAGES-1:0] fill_reg, fill_next;
  logic hist1_reg, hist10_reg;
  logic armed1_reg, armed10_reg;
  logic s1_reg, s10_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync1_next[gi]  = tick_1hz;
        assign sync10_next[gi] = tick_10hz;
        assign fill_next[gi]   = 1'b1;
      end else begin : g_chain
        assign sync1_next[gi]  = sync1_reg[gi-1];
        assign sync10_next[gi] = sync10_reg[gi-1];
        assign fill_next[gi]   = fill_reg[gi-1];
      end
    end
  endgenerate

  // fill_reg marks when the chain output reflects a real input sample, so an input
  // already high at reset release must be seen low before it can arm a strobe.
  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      sync1_reg   <= '0;
      sync10_reg  <= '0;
      fill_reg    <= '0;
      hist1_reg   <= 1'b0;
      hist10_reg  <= 1'b0;
      armed1_reg  <= 1'b0;
      armed10_reg <= 1'b0;
      s1_reg      <= 1'b0;
      s10_reg     <= 1'b0;
    end else begin
      sync1_reg   <= sync1_next;
      sync10_reg  <= sync10_next;
      fill_reg    <= fill_next;
      hist1_reg   <= sync1_reg[LAST];
      hist10_reg  <= sync10_reg[LAST];
      armed1_reg  <= armed1_reg  | (fill_reg[LAST] & ~sync1_reg[LAST]);
      armed10_reg <= armed10_reg | (fill_reg[LAST] & ~sync10_reg[LAST]);
      s1_reg      <= sync1_reg[LAST]  & ~hist1_reg  & armed1_reg;
      s10_reg     <= sync10_reg[LAST] & ~hist10_reg & armed10_reg;
    end
  end

  mode_t      mode_now;
  mode_t      mode_prev_reg;
  logic [7:0] hour_reg, hour_next;
  logic [7:0] min_reg, min_next;
  logic [7:0] sec_reg, sec_next;
  logic       strobe_reg, strobe_next;
  logic       chime_reg, chime_next;

  assign mode_now = mode_t'(mode);

  always_comb begin
    hour_next   = hour_reg;
    min_next    = min_reg;
    sec_next    = sec_reg;
    strobe_next = 1'b0;
    chime_next  = 1'b0;
    case (mode_now)
      MODE_RUN: begin
        if (s1_reg && !sec_clr) begin
          sec_next    = bcd_inc(sec_reg, 8'h59, 8'h00);
          strobe_next = 1'b1;
          if (sec_reg == 8'h59) begin
            min_next = bcd_inc(min_reg, 8'h59, 8'h00);
            if (min_reg == 8'h59) begin
              hour_next  = bcd_inc(hour_reg, HOUR_TOP, HOUR_BASE);
              chime_next = 1'b1;
            end
          end
        end
      end
      MODE_SET_HOUR: begin
        if (s10_reg && adj)
          hour_next = bcd_inc(hour_reg, HOUR_TOP, HOUR_BASE);
      end
      MODE_SET_MIN: begin
        if (s10_reg && adj)
          min_next = bcd_inc(min_reg, 8'h59, 8'h00);
        if (mode_prev_reg != MODE_SET_MIN)
          sec_next = 8'h00;
      end
      default: begin
      end
    endcase
    // A clear wins over a coincident second tick; the tick is simply lost.
    if (sec_clr)
      sec_next = 8'h00;
  end

  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      hour_reg      <= HOUR_RESET;
      min_reg       <= 8'h00;
      sec_reg       <= 8'h00;
      strobe_reg    <= 1'b0;
      chime_reg     <= 1'b0;
      mode_prev_reg <= MODE_RUN;
    end else begin
      hour_reg      <= hour_next;
      min_reg       <= min_next;
      sec_reg       <= sec_next;
      strobe_reg    <= strobe_next;
      chime_reg     <= chime_next;
      mode_prev_reg <= mode_now;
    end
  end

  assign hour_bcd   = hour_reg;
  assign min_bcd    = min_reg;
  assign sec_bcd    = sec_reg;
  assign sec_strobe = strobe_reg;
  assign chime      = chime_reg;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a 24h instance and a 12h instance share one stimulus stream.
module tb_time_keeper;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       cr_n;
  logic       tick_1hz, tick_10hz, adj, sec_clr;
  logic [1:0] mode;
  logic [7:0] hour24, min24, sec24, hour12, min12, sec12;
  logic       strobe24, chime24, strobe12, chime12;

  int passed = 0;
  int total  = 0;
  int strobe_cnt = 0;
  int chime_cnt  = 0;
  int base_s, base_c, pos, npulse;

  always #5 clk = ~clk;

  time_keeper #(.SYNC_STAGES(SYNC), .HOUR_WRAP(24)) dut24 (
    .CP(clk), ._CR(cr_n), .tick_1hz(tick_1hz), .tick_10hz(tick_10hz),
    .mode(mode), .adj(adj), .sec_clr(sec_clr),
    .hour_bcd(hour24), .min_bcd(min24), .sec_bcd(sec24),
    .sec_strobe(strobe24), .chime(chime24)
  );

  time_keeper #(.SYNC_STAGES(SYNC), .HOUR_WRAP(12)) dut12 (
    .CP(clk), ._CR(cr_n), .tick_1hz(tick_1hz), .tick_10hz(tick_10hz),
    .mode(mode), .adj(adj), .sec_clr(sec_clr),
    .hour_bcd(hour12), .min_bcd(min12), .sec_bcd(sec12),
    .sec_strobe(strobe12), .chime(chime12)
  );

  always @(negedge clk) begin
    if (strobe24) strobe_cnt++;
    if (chime24)  chime_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick1(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) tick_1hz = 1'b1;
      repeat (SYNC + 4) @(negedge clk);
      tick_1hz = 1'b0;
      repeat (SYNC + 2) @(negedge clk);
    end
  endtask

  task automatic tick10(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) tick_10hz = 1'b1;
      repeat (SYNC + 4) @(negedge clk);
      tick_10hz = 1'b0;
      repeat (SYNC + 2) @(negedge clk);
    end
  endtask

  initial begin
    cr_n = 1'b0; tick_1hz = 1'b0; tick_10hz = 1'b0;
    adj = 1'b0; sec_clr = 1'b0; mode = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_time24", {hour24, min24, sec24}, 24'h000000);
    check("reset_time12", {hour12, min12, sec12}, 24'h120000);
    check("reset_pulses", {strobe24, chime24, strobe12, chime12}, 4'b0000);
    cr_n = 1'b1;
    repeat (5) @(negedge clk);

    // three timed ticks in run mode
    base_s = strobe_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) tick_1hz = 1'b1;
      pos = 0; npulse = 0;
      for (int i = 1; i <= SYNC + 5; i++) begin
        @(posedge clk); #1;
        if (strobe24) begin npulse++; pos = i; end
      end
      check("strobe_latency", pos, SYNC + 2);
      check("strobe_width", npulse, 1);
      @(negedge clk) tick_1hz = 1'b0;
      repeat (SYNC + 2) @(negedge clk);
    end
    check("run_3_ticks", {hour24, min24, sec24}, 24'h000003);
    check("run_3_strobes", strobe_cnt - base_s, 3);

    // preload 23:59:58
    @(negedge clk) mode = 2'b01; adj = 1'b1;
    tick10(23);
    check("set_hour_23", {hour24, min24, sec24}, 24'h230003);
    base_s = strobe_cnt;
    tick1(2);
    check("set_hour_sec_frozen", {hour24, min24, sec24}, 24'h230003);
    check("set_hour_no_strobe", strobe_cnt - base_s, 0);
    @(negedge clk) mode = 2'b10;
    @(negedge clk);
    check("set_min_entry_clear", sec24, 8'h00);
    tick10(59);
    check("set_min_59", {hour24, min24, sec24}, 24'h235900);
    @(negedge clk) adj = 1'b0;
    tick10(2);
    check("adj_low_no_change", {hour24, min24, sec24}, 24'h235900);
    @(negedge clk) mode = 2'b00;
    tick1(58);
    check("run_to_58", {hour24, min24, sec24}, 24'h235958);
    base_c = chime_cnt;
    tick1(1);
    check("run_to_59", {hour24, min24, sec24}, 24'h235959);
    check("no_chime_at_59", chime_cnt - base_c, 0);
    tick1(1);
    check("day_rollover24", {hour24, min24, sec24}, 24'h000000);
    check("chime_once", chime_cnt - base_c, 1);
    check("rollover12_11_to_12", {hour12, min12, sec12}, 24'h120000);

    // hour wrap in set mode, minute wrap without carry
    @(negedge clk) mode = 2'b01; adj = 1'b1;
    tick10(22);
    check("set_hour_22", hour24, 8'h22);
    tick10(5);
    check("set_hour_wrap_03", {hour24, min24, sec24}, 24'h030000);
    check("set_hour12_wrap_03", hour12, 8'h03);
    @(negedge clk) mode = 2'b10;
    tick10(58);
    check("set_min_58", {hour24, min24, sec24}, 24'h035800);
    tick10(3);
    check("set_min_wrap_01", {hour24, min24, sec24}, 24'h030100);

    // sec_clr coincident with a tick at xx:10:59
    tick10(9);
    @(negedge clk) mode = 2'b00; adj = 1'b0;
    tick1(59);
    check("pre_clr", {hour24, min24, sec24}, 24'h031059);
    base_s = strobe_cnt; base_c = chime_cnt;
    @(negedge clk) tick_1hz = 1'b1; sec_clr = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    sec_clr = 1'b0; tick_1hz = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    check("clr_beats_tick", {hour24, min24, sec24}, 24'h031000);
    check("clr_no_strobe", strobe_cnt - base_s, 0);
    check("clr_no_chime", chime_cnt - base_c, 0);

    // hold mode ignores both ticks
    @(negedge clk) mode = 2'b11; adj = 1'b1;
    base_s = strobe_cnt;
    tick1(10);
    tick10(3);
    check("hold_frozen24", {hour24, min24, sec24}, 24'h031000);
    check("hold_frozen12", {hour12, min12, sec12}, 24'h031000);
    check("hold_no_strobe", strobe_cnt - base_s, 0);

    // 07:31:42 then asynchronous reset with tick_1hz held high
    @(negedge clk) mode = 2'b01;
    tick10(4);
    @(negedge clk) mode = 2'b10;
    tick10(21);
    @(negedge clk) mode = 2'b00; adj = 1'b0;
    tick1(42);
    check("pre_reset", {hour24, min24, sec24}, 24'h073142);
    @(negedge clk) tick_1hz = 1'b1;
    @(posedge clk); #2;
    cr_n = 1'b0;
    #1;
    check("async_reset24", {hour24, min24, sec24}, 24'h000000);
    check("async_reset12", {hour12, min12, sec12}, 24'h120000);
    repeat (3) @(negedge clk);
    cr_n = 1'b1;
    base_s = strobe_cnt;
    repeat (10) @(negedge clk);
    check("high_at_release_ignored", sec24, 8'h00);
    check("high_at_release_no_strobe", strobe_cnt - base_s, 0);
    tick_1hz = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    tick1(1);
    check("fresh_edge_counts", {hour24, min24, sec24}, 24'h000001);

    // 12h wrap: 12:59:59 -> 01:00:00
    @(negedge clk) sec_clr = 1'b1;
    @(negedge clk) sec_clr = 1'b0;
    check("sec_clr_plain", sec24, 8'h00);
    @(negedge clk) mode = 2'b10; adj = 1'b1;
    tick10(59);
    @(negedge clk) mode = 2'b00; adj = 1'b0;
    tick1(59);
    check("pre_wrap12", {hour12, min12, sec12}, 24'h125959);
    base_c = chime_cnt;
    tick1(1);
    check("wrap12_to_01", {hour12, min12, sec12}, 24'h010000);
    check("wrap24_to_01", {hour24, min24, sec24}, 24'h010000);
    check("wrap_chime", chime_cnt - base_c, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
